// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: host-side program/readback controller for one configuration chain
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 160,
  parameter int WORD_W = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              mode,
  input  logic              abort,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_en,
  output logic              busy,
  output logic              done
);
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int WC_W = $clog2(WORD_W + 1);
  typedef enum logic [2:0] {IDLE, PGM_FETCH, PGM_SHIFT, RB_SHIFT, RB_OUT, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WC_W-1:0] word_cnt_q, word_cnt_d, take;
  logic [WORD_W-1:0] sreg_q, sreg_d, rsreg_q, rsreg_d;
  logic chain_end;
  int rem;
  always_comb begin
    rem = CHAIN_LEN - int'(bit_cnt_q);
    take = (rem < WORD_W) ? WC_W'(rem) : WC_W'(WORD_W);
    chain_end = bit_cnt_q == CNT_W'(CHAIN_LEN - 1);
    state_d = state_q;
    bit_cnt_d = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    sreg_d = sreg_q;
    rsreg_d = rsreg_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = mode ? RB_SHIFT : PGM_FETCH;
        bit_cnt_d = '0;
        word_cnt_d = '0;
        rsreg_d = '0;
      end
      PGM_FETCH: if (wr_valid) begin
        sreg_d = wr_data;
        word_cnt_d = take;
        state_d = PGM_SHIFT;
      end
      PGM_SHIFT: begin
        sreg_d = sreg_q >> 1;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        word_cnt_d = word_cnt_q - WC_W'(1);
        if (word_cnt_q == WC_W'(1)) state_d = chain_end ? DONE : PGM_FETCH;
      end
      // word_cnt doubles as the bit index inside the readback word
      RB_SHIFT: begin
        rsreg_d = rsreg_q | (WORD_W'(ccff_tail) << word_cnt_q);
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        word_cnt_d = word_cnt_q + WC_W'(1);
        if (chain_end || word_cnt_q == WC_W'(WORD_W - 1)) begin
          word_cnt_d = '0;
          state_d = RB_OUT;
        end
      end
      RB_OUT: if (rd_ready) begin
        state_d = (bit_cnt_q == CNT_W'(CHAIN_LEN)) ? DONE : RB_SHIFT;
        rsreg_d = (bit_cnt_q == CNT_W'(CHAIN_LEN)) ? rsreg_q : '0;
      end
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) state_d = IDLE;
  end
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_q <= IDLE;
      bit_cnt_q <= '0;
      word_cnt_q <= '0;
      sreg_q <= '0;
      rsreg_q <= '0;
    end else begin
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      sreg_q <= sreg_d;
      rsreg_q <= rsreg_d;
    end
  end
  assign busy = state_q != IDLE;
  assign wr_ready = state_q == PGM_FETCH && !abort;
  assign rd_valid = state_q == RB_OUT;
  assign rd_data = rsreg_q;
  assign ccff_en = (state_q == PGM_SHIFT || state_q == RB_SHIFT) && !abort;
  assign ccff_head = (state_q == PGM_SHIFT) ? sreg_q[0] : (state_q == RB_SHIFT) ? ccff_tail : 1'b0;
  assign done = state_q == DONE && !abort;
endmodule
